// File: rtl/imm_encoder_if.sv
// Request/response bundle for imm_encoder: template + immediate in, encoded word out.
// slave is the encoder side, master is the producer/consumer side.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [2:0]  in_type;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic        out_last;

  modport master (
    output in_valid, in_inst, in_type, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_err, out_last
  );

  modport slave (
    input  in_valid, in_inst, in_type, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_err, out_last
  );
endinterface

// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into the I/S/B/J/U fields of a template instruction, one output register.
// Optional IMM_ENCODER_LI_EXPAND_EN splits out-of-range ADDI into a LUI + ADDI pair.
module imm_encoder #(
  parameter logic [31:0] RESET_INST = 32'h00000013
) (
  input  logic         clk,
  input  logic         rst_n,
  imm_encoder_if.slave io
);

  // state  | meaning
  // IDLE   | no pending beat; output register free to load a new request
  // SECOND | LUI beat on the output, ADDI beat held in pend_inst_q
  typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_e;

  state_e      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        out_err_q, out_err_d;
  logic        out_last_q, out_last_d;

  logic        in_ready;
  logic        accept;
  logic        i_ok, b_ok, j_ok;
  logic [31:0] enc_inst;
  logic        enc_err;

  assign in_ready = (~out_valid_q | io.out_ready) & (state_q != SECOND);
  assign accept   = io.in_valid & in_ready;

  // Representable iff every bit above the field's sign bit equals it.
  assign i_ok = (&io.in_imm[31:11]) | ~(|io.in_imm[31:11]);
  assign b_ok = ((&io.in_imm[31:12]) | ~(|io.in_imm[31:12])) & ~io.in_imm[0];
  assign j_ok = ((&io.in_imm[31:20]) | ~(|io.in_imm[31:20])) & ~io.in_imm[0];

  always_comb begin
    enc_inst = io.in_inst;
    enc_err  = 1'b0;
    case (io.in_type)
      3'b000: begin
        enc_inst[31:20] = io.in_imm[11:0];
        enc_err         = ~i_ok;
      end
      3'b001: begin
        enc_inst[31:25] = io.in_imm[11:5];
        enc_inst[11:7]  = io.in_imm[4:0];
        enc_err         = ~i_ok;
      end
      3'b010: begin
        enc_inst[31]    = io.in_imm[12];
        enc_inst[7]     = io.in_imm[11];
        enc_inst[30:25] = io.in_imm[10:5];
        enc_inst[11:8]  = io.in_imm[4:1];
        enc_err         = ~b_ok;
      end
      3'b011: begin
        enc_inst[31]    = io.in_imm[20];
        enc_inst[30:21] = io.in_imm[10:1];
        enc_inst[20]    = io.in_imm[11];
        enc_inst[19:12] = io.in_imm[19:12];
        enc_err         = ~j_ok;
      end
      3'b100: begin
        enc_inst[31:12] = io.in_imm[31:12];
        enc_err         = |io.in_imm[11:0];
      end
      default: enc_err = 1'b1;
    endcase
  end

`ifdef IMM_ENCODER_LI_EXPAND_EN
  logic [31:0] pend_inst_q, pend_inst_d;
  logic        expand;
  logic [19:0] lui_hi;
  logic [31:0] lui_inst, addi_inst;

  assign expand    = (io.in_type == 3'b000) & (io.in_inst[6:0] == 7'b0010011) &
                     (io.in_inst[14:12] == 3'b000) & ~i_ok;
  // imm + 0x800 only affects the upper field through the carry out of bit 11.
  assign lui_hi    = io.in_imm[31:12] + {19'd0, io.in_imm[11]};
  assign lui_inst  = {lui_hi, io.in_inst[11:7], 7'b0110111};
  assign addi_inst = {io.in_imm[11:0], io.in_inst[11:7], io.in_inst[14:0]};
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_err_d   = out_err_q;
    out_last_d  = out_last_q;
`ifdef IMM_ENCODER_LI_EXPAND_EN
    pend_inst_d = pend_inst_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_inst_d  = enc_inst;
          out_err_d   = enc_err;
          out_last_d  = 1'b1;
`ifdef IMM_ENCODER_LI_EXPAND_EN
          if (expand) begin
            out_inst_d  = lui_inst;
            out_err_d   = 1'b0;
            out_last_d  = 1'b0;
            pend_inst_d = addi_inst;
            state_d     = SECOND;
          end
`endif
        end else if (io.out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      SECOND: begin
        if (io.out_ready) begin
`ifdef IMM_ENCODER_LI_EXPAND_EN
          out_inst_d = pend_inst_q;
`endif
          out_err_d  = 1'b0;
          out_last_d = 1'b1;
          state_d    = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_inst_q  <= RESET_INST;
      out_err_q   <= 1'b0;
      out_last_q  <= 1'b1;
`ifdef IMM_ENCODER_LI_EXPAND_EN
      pend_inst_q <= RESET_INST;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_err_q   <= out_err_d;
      out_last_q  <= out_last_d;
`ifdef IMM_ENCODER_LI_EXPAND_EN
      pend_inst_q <= pend_inst_d;
`endif
    end
  end

  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid_q;
  assign io.out_inst  = out_inst_q;
  assign io.out_err   = out_err_q;
  assign io.out_last  = out_last_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: expected beats queued at accept, compared as they leave.
// Expansion expectations follow IMM_ENCODER_LI_EXPAND_EN when it is defined for the build.
module tb_imm_encoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imm_encoder_if bus ();

  imm_encoder #(.RESET_INST(32'h00000013)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
    logic        last;
    logic        rt;
    logic [2:0]  typ;
    logic [31:0] imm;
  } beat_t;

  beat_t sb[$];
  beat_t mon_b;
  int    n_chk  = 0;
  int    n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic bit in_range(input logic [31:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

  // Core-side immediate extender, used to close the loop on clean encodes.
  function automatic logic [31:0] decode(input logic [31:0] i, input logic [2:0] t);
    case (t)
      3'd0:    return {{20{i[31]}}, i[31:20]};
      3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return {i[31:12], 12'h000};
    endcase
  endfunction

  task automatic push_model(input logic [31:0] t, input logic [2:0] ty, input logic [31:0] imm);
    beat_t b;
    bit    ok;
    logic [31:0] r;
    case (ty)
      3'd0: begin r = (t & 32'h000FFFFF) | {imm[11:0], 20'h0}; ok = in_range(imm, -2048, 2047); end
      3'd1: begin r = (t & 32'h01FFF07F) | {imm[11:5], 13'h0, imm[4:0], 7'h0}; ok = in_range(imm, -2048, 2047); end
      3'd2: begin
        r  = (t & 32'h01FFF07F) | {imm[12], imm[10:5], 13'h0, imm[4:1], imm[11], 7'h0};
        ok = in_range(imm, -4096, 4095) && !imm[0];
      end
      3'd3: begin
        r  = (t & 32'h00000FFF) | {imm[20], imm[10:1], imm[11], imm[19:12], 12'h0};
        ok = in_range(imm, -1048576, 1048575) && !imm[0];
      end
      3'd4: begin r = (t & 32'h00000FFF) | {imm[31:12], 12'h0}; ok = (imm[11:0] == 12'h0); end
      default: begin r = t; ok = 1'b0; end
    endcase
`ifdef IMM_ENCODER_LI_EXPAND_EN
    if (ty == 3'd0 && t[6:0] == 7'h13 && t[14:12] == 3'd0 && !ok) begin
      logic [31:0] hi;
      hi = imm + 32'h800;
      b = '{inst: {hi[31:12], t[11:7], 7'h37}, err: 1'b0, last: 1'b0, rt: 1'b0, typ: ty, imm: imm};
      sb.push_back(b);
      b.inst = (t & 32'h00007FFF) | {imm[11:0], 20'h0} | ({27'h0, t[11:7]} << 15);
      b.last = 1'b1;
      sb.push_back(b);
      return;
    end
`endif
    b = '{inst: r, err: !ok, last: 1'b1, rt: ok, typ: ty, imm: imm};
    sb.push_back(b);
  endtask

  // mode 0: model; 1: one explicit beat; 2: explicit LUI/ADDI pair
  task automatic drive(input logic [31:0] t, input logic [2:0] ty, input logic [31:0] imm,
                       input int mode, input logic [31:0] x1, input bit x_err,
                       input logic [31:0] x2, output int stalls);
    bus.in_inst  = t;
    bus.in_type  = ty;
    bus.in_imm   = imm;
    bus.in_valid = 1'b1;
    stalls = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        if (mode == 0) push_model(t, ty, imm);
        else if (mode == 1)
          sb.push_back('{inst: x1, err: x_err, last: 1'b1, rt: !x_err, typ: ty, imm: imm});
        else begin
          sb.push_back('{inst: x1, err: 1'b0, last: 1'b0, rt: 1'b0, typ: ty, imm: imm});
          sb.push_back('{inst: x2, err: 1'b0, last: 1'b1, rt: 1'b0, typ: ty, imm: imm});
        end
        @(posedge clk); #2;
        return;
      end
      stalls++;
      @(posedge clk); #2;
    end
    check("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic dx(input logic [31:0] t, input logic [2:0] ty, input logic [31:0] imm,
                    input logic [31:0] x, input bit e, output int stalls);
    drive(t, ty, imm, 1, x, e, 32'h0, stalls);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
      if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else begin
        mon_b = sb[0];
        check("out_inst", bus.out_inst, mon_b.inst);
        check("out_err", 32'(bus.out_err), 32'(mon_b.err));
        check("out_last", 32'(bus.out_last), 32'(mon_b.last));
        if (bus.out_ready) begin
          void'(sb.pop_front());
          if (mon_b.rt) check("round_trip", decode(bus.out_inst, mon_b.typ), mon_b.imm);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int  s, s_sum, s_a, s_b, s_c;
  bit  rand_done;

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_inst   = '0;
    bus.in_type   = '0;
    bus.in_imm    = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_inst", bus.out_inst, 32'h00000013);
    check("rst_out_err", 32'(bus.out_err), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #2;

    s_sum = 0;
    dx(32'h00000513, 3'd0, 32'hFFFFFFFF, 32'hFFF00513, 1'b0, s); s_sum += s;
    dx(32'h00002513, 3'd0, 32'd2048,     32'h80002513, 1'b1, s); s_sum += s;
    dx(32'h00000513, 3'd0, 32'hFFFFF800, 32'h80000513, 1'b0, s); s_sum += s;
    dx(32'h00000513, 3'd0, 32'd2047,     32'h7FF00513, 1'b0, s); s_sum += s;
    dx(32'h00A52023, 3'd1, 32'hFFFFFFF8, 32'hFEA52C23, 1'b0, s); s_sum += s;
    dx(32'h00000063, 3'd2, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0, s); s_sum += s;
    dx(32'h00000063, 3'd2, 32'd6,        32'h00000363, 1'b0, s); s_sum += s;
    dx(32'h00000063, 3'd2, 32'd3,        32'h00000163, 1'b1, s); s_sum += s;
    dx(32'h00000063, 3'd2, 32'hFFFFF000, 32'h80000063, 1'b0, s); s_sum += s;
    dx(32'h00000063, 3'd2, 32'd4096,     32'h80000063, 1'b1, s); s_sum += s;
    dx(32'h000000EF, 3'd3, 32'h000FFFFE, 32'h7FFFF0EF, 1'b0, s); s_sum += s;
    dx(32'h000000EF, 3'd7, 32'h00000123, 32'h000000EF, 1'b1, s); s_sum += s;
    dx(32'h12345678, 3'd5, 32'h00000000, 32'h12345678, 1'b1, s); s_sum += s;
    dx(32'h00000537, 3'd4, 32'h12345000, 32'h12345537, 1'b0, s); s_sum += s;
    dx(32'h00000537, 3'd4, 32'h12345001, 32'h12345537, 1'b1, s); s_sum += s;
    check("tput_stalls", 32'(s_sum), 32'd0);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk); #2;

    // Backpressure: consumer stalls for three cycles while requests queue up.
    bus.out_ready = 1'b0;
    fork
      begin
        drive(32'h00000513, 3'd0, 32'd100, 0, 32'h0, 1'b0, 32'h0, s_a);
        drive(32'h00A52023, 3'd1, 32'd12,  0, 32'h0, 1'b0, 32'h0, s_b);
        drive(32'h000000EF, 3'd3, 32'd64,  0, 32'h0, 1'b0, 32'h0, s_c);
        bus.in_valid = 1'b0;
      end
      begin
        @(posedge clk);
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk); #2;
        bus.out_ready = 1'b1;
      end
    join
    check("bp_stall_a", 32'(s_a), 32'd0);
    check("bp_stall_b", 32'(s_b), 32'd3);
    check("bp_stall_c", 32'(s_c), 32'd0);

    // Random mix with random consumer readiness.
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 60; n++) begin
          logic [31:0] imm;
          case ($urandom_range(0, 3))
            0:       imm = $urandom;
            1:       imm = {{19{1'b0}}, 13'($urandom)} - 32'd4096;
            2:       imm = {12'h0, 20'($urandom)} & 32'hFFFFFFFE;
            default: imm = {20'($urandom), 12'h000};
          endcase
          drive($urandom, 3'($urandom_range(0, 5)), imm, 0, 32'h0, 1'b0, 32'h0, s);
        end
        bus.in_valid = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #2;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join

    // Out-of-range ADDI: LUI/ADDI pair when expansion is built in, error beat otherwise.
`ifdef IMM_ENCODER_LI_EXPAND_EN
    drive(32'h00000513, 3'd0, 32'h12345FFF, 2, 32'h12346537, 1'b0, 32'hFFF50513, s);
    drive(32'h00002513, 3'd0, 32'd5, 0, 32'h0, 1'b0, 32'h0, s);
    check("li_in_ready_stall", 32'(s), 32'd1);
`else
    dx(32'h00000513, 3'd0, 32'h12345FFF, 32'hFFF00513, 1'b1, s);
    drive(32'h00002513, 3'd0, 32'd5, 0, 32'h0, 1'b0, 32'h0, s);
    check("li_in_ready_stall", 32'(s), 32'd0);
`endif
    drive(32'h00000013, 3'd0, 32'hFFFF0000, 0, 32'h0, 1'b0, 32'h0, s);
    drive(32'h00000513, 3'd0, 32'd2048,     0, 32'h0, 1'b0, 32'h0, s);
    bus.in_valid = 1'b0;

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    #2;
    check("drain_empty", 32'(sb.size()), 32'd0);

    // Asynchronous reset while a beat is held by backpressure.
    bus.out_ready = 1'b0;
    drive(32'h00000513, 3'd0, 32'd5, 0, 32'h0, 1'b0, 32'h0, s);
    bus.in_valid = 1'b0;
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_inst", bus.out_inst, 32'h00000013);
    check("mid_rst_out_err", 32'(bus.out_err), 32'd0);
    check("mid_rst_out_last", 32'(bus.out_last), 32'd1);
    sb.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
